// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit for the rv32i core.
// Sequences each instruction through fetch/decode/execute/memory/writeback
// states over a shared memory port, drives the datapath strobes and muxes,
// supervises memory wait states with an optional timeout, traps illegal
// opcodes and counts retired instructions.
module multicycle_ctrl_fsm #(
  parameter int CNT_W     = 32,
  parameter int TRAP_HALT = 1,
  parameter int JAL_LINK  = 1,
  parameter int TIMEOUT   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             mem_write,
  output logic             reg_write,
  output logic             branch,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;
  localparam logic [6:0] OP_RTYPE = 7'd51;
  localparam logic [6:0] OP_ITYPE = 7'd19;
  localparam logic [6:0] OP_BEQ   = 7'd99;
  localparam logic [6:0] OP_JAL   = 7'd111;

  // Wait counter only needs to reach TIMEOUT-1; the expiring cycle is the
  // TIMEOUT-th consecutive cycle without mem_ready.
  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = (TIMEOUT > 0) ? WCW'(TIMEOUT - 1) : '0;

  state_t         cur;
  state_t         nxt;
  logic [WCW-1:0] wait_cnt;
  logic           mem_state;
  logic           expired;
  logic           retire;
  logic           mem_req_s;
  logic           ir_write_s;
  logic           pc_write_s;
  logic           mem_write_s;
  logic           reg_write_s;
  logic           branch_s;

  assign mem_state = (cur == S_FETCH) || (cur == S_MEMREAD) || (cur == S_MEMWRITE);
  assign expired   = (TIMEOUT > 0) && mem_state && !mem_ready && (wait_cnt == WAIT_LAST);

  // State register: async reset returns to fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  // Wait-state counter: restarts on every state change, counts stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        wait_cnt <= '0;
    else if (nxt != cur)              wait_cnt <= '0;
    else if (mem_state && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
  end

  // Sticky bus error, set by a memory timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        bus_err <= 1'b0;
    else if (expired) bus_err <= 1'b1;
  end

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

  // Next-state logic and Moore datapath controls.
  always_comb begin
    nxt         = cur;
    mem_req_s   = 1'b0;
    adr_src     = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    branch_s    = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    result_src  = 2'b00;
    illegal     = 1'b0;
    retire      = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req_s  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          nxt        = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: nxt = S_MEMADR;
          OP_RTYPE:          nxt = S_EXECUTER;
          OP_ITYPE:          nxt = S_EXECUTEI;
          OP_BEQ:            nxt = S_BEQ;
          OP_JAL:            nxt = S_JAL;
          default:           nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        nxt       = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_s = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
        retire      = 1'b1;
        nxt         = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_s   = 1'b1;
        adr_src     = 1'b1;
        mem_write_s = !expired;
        if (mem_ready) begin
          retire = 1'b1;
          nxt    = S_FETCH;
        end
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        nxt       = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        nxt       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        retire      = 1'b1;
        nxt         = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch_s  = 1'b1;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_s = 1'b1;
        if (JAL_LINK != 0) begin
          nxt = S_ALUWB;
        end else begin
          retire = 1'b1;
          nxt    = S_FETCH;
        end
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        if (TRAP_HALT == 0) nxt = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
    if (expired) nxt = S_ILLEGAL;
  end

  // Immediate format select, decoded straight from the opcode.
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_STORE: imm_src = 2'b01;
      OP_BEQ:   imm_src = 2'b10;
      OP_JAL:   imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

  // Strobes are forced low while reset is held, even though fetch is shown.
  assign mem_req   = mem_req_s   & ~reset;
  assign ir_write  = ir_write_s  & ~reset;
  assign pc_write  = pc_write_s  & ~reset;
  assign mem_write = mem_write_s & ~reset;
  assign reg_write = reg_write_s & ~reset;
  assign branch    = branch_s    & ~reset;
  assign state     = cur;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed testbench for multicycle_ctrl_fsm.
// Instance u0 uses the default parameters; u1 uses CNT_W=4, TRAP_HALT=0,
// JAL_LINK=0, TIMEOUT=4.
module tb_multicycle_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset0, reset1;
  logic [6:0]  op0, op1;
  logic        ready0, ready1;
  logic        mem_req0, adr_src0, ir_write0, pc_write0, mem_write0, reg_write0, branch0;
  logic        mem_req1, adr_src1, ir_write1, pc_write1, mem_write1, reg_write1, branch1;
  logic [1:0]  a0, b0, aluop0, rs0, imm0;
  logic [1:0]  a1, b1, aluop1, rs1, imm1;
  logic        illegal0, bus_err0, illegal1, bus_err1;
  logic [31:0] instret0;
  logic [3:0]  instret1;
  logic [3:0]  state0, state1;

  int n_checks = 0;
  int n_pass   = 0;
  int branch_cnt, regw_cnt, pcw_jal;

  multicycle_ctrl_fsm u0 (
    .clk(clk), .reset(reset0), .op(op0), .mem_ready(ready0),
    .mem_req(mem_req0), .adr_src(adr_src0), .ir_write(ir_write0),
    .pc_write(pc_write0), .mem_write(mem_write0), .reg_write(reg_write0),
    .branch(branch0), .alu_src_a(a0), .alu_src_b(b0), .alu_op(aluop0),
    .result_src(rs0), .imm_src(imm0), .illegal(illegal0), .bus_err(bus_err0),
    .instret(instret0), .state(state0)
  );

  multicycle_ctrl_fsm #(.CNT_W(4), .TRAP_HALT(0), .JAL_LINK(0), .TIMEOUT(4)) u1 (
    .clk(clk), .reset(reset1), .op(op1), .mem_ready(ready1),
    .mem_req(mem_req1), .adr_src(adr_src1), .ir_write(ir_write1),
    .pc_write(pc_write1), .mem_write(mem_write1), .reg_write(reg_write1),
    .branch(branch1), .alu_src_a(a1), .alu_src_b(b1), .alu_op(aluop1),
    .result_src(rs1), .imm_src(imm1), .illegal(illegal1), .bus_err(bus_err1),
    .instret(instret1), .state(state1)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int inst, input logic [6:0] opc, input logic rdy);
    if (inst == 0) begin
      op0 = opc; ready0 = rdy;
    end else begin
      op1 = opc; ready1 = rdy;
    end
    #1;
  endtask

  function automatic logic [3:0] cur_state(input int inst);
    return (inst == 0) ? state0 : state1;
  endfunction

  // Runs one instruction from FETCH back to FETCH with mem_ready high,
  // tallying strobes and checking the cycle count.
  task automatic run_instr(input int inst, input logic [6:0] opc, input int exp_cycles, input string tag);
    int cyc = 0;
    apply_stimulus(inst, opc, 1'b1);
    do begin
      if (inst == 0) begin
        if (branch0) branch_cnt++;
        if (reg_write0) regw_cnt++;
        if (state0 == 4'd10 && pc_write0) pcw_jal++;
        if (state0 == 4'd6) check_output("execr_ctl", {28'd0, aluop0, b0}, {28'd0, 2'b10, 2'b00});
        if (state0 == 4'd9) check_output("beq_ctl", {28'd0, aluop0, a0}, {28'd0, 2'b01, 2'b10});
      end else begin
        if (branch1) branch_cnt++;
        if (reg_write1) regw_cnt++;
        if (state1 == 4'd10 && pc_write1) pcw_jal++;
      end
      tick();
      cyc++;
    end while (cur_state(inst) != 4'd0 && cyc < 40);
    check_output(tag, cyc, exp_cycles);
  endtask

  initial begin
    reset0 = 1'b1; reset1 = 1'b1;
    op0 = 7'd0; op1 = 7'd0;
    ready0 = 1'b1; ready1 = 1'b0;
    #2;
    // Reset state: strobes gated, fetch encoding visible
    check_output("rst_state", state0, 4'd0);
    check_output("rst_memreq", mem_req0, 1'b0);
    check_output("rst_irwrite", ir_write0, 1'b0);
    check_output("rst_srcb", b0, 2'b10);
    check_output("rst_instret", instret0, 32'd0);
    check_output("rst_buserr", bus_err0, 1'b0);
    tick();
    reset0 = 1'b0;

    // lw
    apply_stimulus(0, 7'd3, 1'b1);
    check_output("lw_fetch", {mem_req0, ir_write0, pc_write0, adr_src0, rs0}, {1'b1, 1'b1, 1'b1, 1'b0, 2'b10});
    tick();
    check_output("lw_decode", {state0, a0, b0, imm0}, {4'd1, 2'b01, 2'b01, 2'b00});
    tick();
    check_output("lw_memadr", {state0, a0, b0}, {4'd2, 2'b10, 2'b01});
    tick();
    check_output("lw_memread", {state0, mem_req0, adr_src0, reg_write0}, {4'd3, 1'b1, 1'b1, 1'b0});
    tick();
    check_output("lw_memwb", {state0, reg_write0, rs0}, {4'd4, 1'b1, 2'b01});
    check_output("lw_instret_pre", instret0, 32'd0);
    tick();
    check_output("lw_done_state", state0, 4'd0);
    check_output("lw_instret", instret0, 32'd1);

    // sw with 3 wait cycles
    apply_stimulus(0, 7'd35, 1'b1);
    check_output("sw_imm", imm0, 2'b01);
    tick();
    tick();
    apply_stimulus(0, 7'd35, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) apply_stimulus(0, 7'd35, 1'b1);
      check_output("sw_wait", {state0, mem_write0, adr_src0, reg_write0}, {4'd5, 1'b1, 1'b1, 1'b0});
      tick();
    end
    check_output("sw_done_state", state0, 4'd0);
    check_output("sw_instret", instret0, 32'd2);

    apply_stimulus(0, 7'd99, 1'b0);
    check_output("imm_beq", imm0, 2'b10);
    apply_stimulus(0, 7'd111, 1'b0);
    check_output("imm_jal", imm0, 2'b11);

    // R, I, beq, jal back to back
    branch_cnt = 0; regw_cnt = 0; pcw_jal = 0;
    run_instr(0, 7'd51, 4, "cyc_r");
    run_instr(0, 7'd19, 4, "cyc_i");
    run_instr(0, 7'd99, 3, "cyc_beq");
    run_instr(0, 7'd111, 4, "cyc_jal_link");
    check_output("btb_branch_cnt", branch_cnt, 1);
    check_output("btb_regw_cnt", regw_cnt, 3);
    check_output("btb_pcw_jal", pcw_jal, 1);
    check_output("btb_instret", instret0, 32'd6);

    // Illegal opcode, halting trap
    apply_stimulus(0, 7'h7F, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 12; i++) begin
      check_output("trap_hold", {state0, illegal0, mem_req0}, {4'd11, 1'b1, 1'b0});
      tick();
    end
    check_output("trap_instret", instret0, 32'd6);

    // Async reset out of ILLEGAL
    reset0 = 1'b1;
    #1;
    check_output("trap_rst", {state0, illegal0}, {4'd0, 1'b0});
    check_output("trap_rst_instret", instret0, 32'd0);
    tick();
    reset0 = 1'b0;

    // Async reset during a MEMWRITE wait
    apply_stimulus(0, 7'd35, 1'b1);
    tick();
    tick();
    apply_stimulus(0, 7'd35, 1'b0);
    tick();
    tick();
    check_output("abort_pre", {state0, mem_write0}, {4'd5, 1'b1});
    reset0 = 1'b1;
    #1;
    check_output("abort_async", {state0, mem_write0, mem_req0}, {4'd0, 1'b0, 1'b0});
    tick();
    reset0 = 1'b0;
    #1;
    check_output("abort_after", {state0, mem_req0}, {4'd0, 1'b1});
    check_output("abort_instret", instret0, 32'd0);

    // Second configuration
    reset1 = 1'b0;
    branch_cnt = 0; regw_cnt = 0; pcw_jal = 0;
    run_instr(1, 7'd111, 3, "cyc_jal_nolink");
    check_output("nolink_regw", regw_cnt, 0);
    check_output("nolink_pcw", pcw_jal, 1);
    check_output("nolink_instret", {28'd0, instret1}, 32'd1);

    // Non-halting trap: one ILLEGAL cycle
    apply_stimulus(1, 7'h7F, 1'b1);
    tick();
    tick();
    check_output("trap1_state", {state1, illegal1}, {4'd11, 1'b1});
    tick();
    check_output("trap1_back", {state1, illegal1}, {4'd0, 1'b0});
    check_output("trap1_instret", {28'd0, instret1}, 32'd1);

    // Fetch timeout after 4 stalled cycles
    apply_stimulus(1, 7'd51, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_output("to_fetch_wait", {state1, ir_write1, bus_err1}, {4'd0, 1'b0, 1'b0});
      tick();
    end
    check_output("to_illegal", {state1, bus_err1}, {4'd11, 1'b1});
    tick();
    check_output("to_sticky", {state1, bus_err1}, {4'd0, 1'b1});

    reset1 = 1'b1;
    #1;
    check_output("to_rst_clear", {bus_err1, instret1}, {1'b0, 4'd0});
    tick();
    reset1 = 1'b0;

    // mem_ready on the 4th cycle is still a success
    apply_stimulus(1, 7'd51, 1'b0);
    tick();
    tick();
    tick();
    apply_stimulus(1, 7'd51, 1'b1);
    check_output("to_late_ready", {state1, ir_write1}, {4'd0, 1'b1});
    tick();
    check_output("to_late_decode", {state1, bus_err1}, {4'd1, 1'b0});
    tick();
    tick();
    tick();
    check_output("to_late_done", {state1, instret1}, {4'd0, 4'd1});

    // instret wrap at CNT_W=4
    for (int i = 0; i < 14; i++) run_instr(1, 7'd19, 4, "wrap_cyc");
    check_output("wrap_max", {28'd0, instret1}, 32'd15);
    run_instr(1, 7'd19, 4, "wrap_cyc_last");
    check_output("wrap_zero", {28'd0, instret1}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
